flag_unit: RTL and testbench

Producer side of the condition-code path: holds the architectural {Z,V,N} flag register, updates it from the EX-stage ALU result under per-opcode write masks, and delivers the flags the ID-stage branch resolver consumes. Resolves the EX→ID flag hazard either by bypassing freshly computed flags or by stalling decode one cycle. Sits between the ALU (EX) and the branch/next-PC logic (ID).

---
 rtl/flag_unit.sv | 91 +++++++++
 tb/tb_flag_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// Condition-code register {Z,V,N} with EX->ID hazard resolution.
// FLAG_BYPASS_EN selects forwarding; otherwise decode stalls one cycle.
module flag_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] ex_result,
  input  logic        ex_ovf,
  input  logic        ex_flush,
  input  logic        id_valid,
  input  logic [3:0]  id_opcode,
  output logic [2:0]  flags,
  output logic [2:0]  br_flags,
  output logic        stall
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_BZ  = 4'hC;
  localparam logic [3:0] OP_BN  = 4'hD;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

`ifdef FLAG_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic [2:0] mask;
  logic [2:0] calc;
  logic [2:0] nxt;
  logic       ex_wr;
  logic       id_br;
  logic [0:0] state;
  logic [0:0] state_nxt;

  // decode per-opcode flag write mask
  always_comb begin
    mask = 3'b000;
    unique case (1'b1)
      ex_opcode == OP_ADD,
      ex_opcode == OP_SUB: mask = 3'b111;
      ex_opcode == OP_XOR,
      ex_opcode == OP_SLL,
      ex_opcode == OP_SRA,
      ex_opcode == OP_ROR: mask = 3'b100;
      default:             mask = 3'b000;
    endcase
  end

  // merge freshly computed flags into the masked bits
  always_comb begin
    calc  = {ex_result == 16'h0000, ex_ovf, ex_result[15]};
    nxt   = (flags & ~mask) | (calc & mask);
    ex_wr = ex_valid & ~ex_flush & (|mask);
    id_br = id_valid & ((id_opcode == OP_BZ) | (id_opcode == OP_BN));
  end

  // hazard stall and branch-resolver flag view
  always_comb begin
    stall     = rst_n & ~BYP & (state == IDLE) & id_br & ex_wr;
    state_nxt = stall ? HOLD : IDLE;
    br_flags  = flags;
    if (BYP && ex_wr && rst_n)
      br_flags = nxt;
  end

  // architectural flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flags <= 3'b000;
    else if (ex_wr)
      flags <= nxt;
  end

  // one-cycle stall sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: directed spec scenarios plus random traffic
// checked against a bitwise flag model.
module tb_flag_unit;

`ifdef FLAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_result;
  logic        ex_ovf;
  logic        ex_flush;
  logic        id_valid;
  logic [3:0]  id_opcode;
  logic [2:0]  flags;
  logic [2:0]  br_flags;
  logic        stall;

  int checks = 0;
  int failures = 0;

  bit m_z, m_v, m_n;
  bit m_held;

  always #5 clk = ~clk;

  flag_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid  (ex_valid),
    .ex_opcode (ex_opcode),
    .ex_result (ex_result),
    .ex_ovf    (ex_ovf),
    .ex_flush  (ex_flush),
    .id_valid  (id_valid),
    .id_opcode (id_opcode),
    .flags     (flags),
    .br_flags  (br_flags),
    .stall     (stall)
  );

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] mflags();
    return {m_z, m_v, m_n};
  endfunction

  task automatic model_reset();
    m_z = 0; m_v = 0; m_n = 0;
    m_held = 0;
  endtask

  // one clock: drive at posedge+1, check comb at negedge,
  // advance model at the edge, check register at posedge+1
  task automatic cyc(input logic v, input logic [3:0] op,
                     input logic [15:0] res, input logic ovf,
                     input logic fl, input logic iv,
                     input logic [3:0] iop);
    bit wz, wv, wn, wr, br, st;
    bit nz, nv, nn;
    logic [2:0] e_br;
    ex_valid = v; ex_opcode = op; ex_result = res;
    ex_ovf = ovf; ex_flush = fl;
    id_valid = iv; id_opcode = iop;
    #4;
    wz = (op <= 4'h2) || (op >= 4'h4 && op <= 4'h6);
    wv = (op <= 4'h1);
    wn = wv;
    wr = v && !fl && (wz || wv || wn);
    nz = wz ? (res == 0) : m_z;
    nv = wv ? ovf : m_v;
    nn = wn ? res[15] : m_n;
    br = iv && (iop == 4'hC || iop == 4'hD);
    st = !BYP && !m_held && br && wr;
    e_br = (BYP && wr) ? {nz, nv, nn} : mflags();
    chk("stall", {3'b0, stall}, {3'b0, st});
    chk("br_flags", {1'b0, br_flags}, {1'b0, e_br});
    @(posedge clk);
    if (wr) begin
      m_z = nz; m_v = nv; m_n = nn;
    end
    m_held = st;
    #1;
    chk("flags", {1'b0, flags}, {1'b0, mflags()});
  endtask

  initial begin
    rst_n = 0;
    ex_valid = 0; ex_opcode = 0; ex_result = 0;
    ex_ovf = 0; ex_flush = 0; id_valid = 0; id_opcode = 0;
    model_reset();
    #12;
    chk("rst_flags", {1'b0, flags}, 4'h0);
    chk("rst_br", {1'b0, br_flags}, 4'h0);
    chk("rst_stall", {3'b0, stall}, 4'h0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    cyc(1, 4'h1, 16'h0000, 0, 0, 0, 4'h0);
    chk("sub_zero", {1'b0, flags}, 4'b0100);
    cyc(1, 4'h0, 16'h8000, 1, 0, 0, 4'h0);
    chk("add_neg_ovf", {1'b0, flags}, 4'b0011);
    cyc(1, 4'h2, 16'h0000, 0, 0, 0, 4'h0);
    chk("xor_mask", {1'b0, flags}, 4'b0111);
    cyc(1, 4'h8, 16'h0000, 1, 0, 0, 4'h0);
    chk("lw_nowrite", {1'b0, flags}, 4'b0111);
    cyc(1, 4'h1, 16'h0000, 0, 1, 1, 4'hC);
    chk("flush_flags", {1'b0, flags}, 4'b0111);

    cyc(1, 4'h0, 16'h0001, 0, 0, 0, 4'h0);
    chk("clear", {1'b0, flags}, 4'b0000);
    cyc(1, 4'h1, 16'h0000, 0, 0, 1, 4'hC);
    cyc(1, 4'h1, 16'h0000, 0, 0, 1, 4'hC);
    chk("hazard_after", {1'b0, br_flags}, 4'b0100);

    // reset while in the stall follow-up cycle
    cyc(1, 4'h0, 16'h0001, 0, 0, 0, 4'h0);
    cyc(1, 4'h1, 16'h0000, 0, 0, 1, 4'hD);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("midrst_flags", {1'b0, flags}, 4'h0);
    chk("midrst_br", {1'b0, br_flags}, 4'h0);
    chk("midrst_stall", {3'b0, stall}, 4'h0);
    @(posedge clk); #1;
    rst_n = 1;
    cyc(1, 4'h1, 16'h0000, 0, 0, 1, 4'hD);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(0, 3) == 0) r = 16'h0000;
      cyc(1'($urandom_range(0, 7) != 0),
          4'($urandom_range(0, 15)), r,
          1'($urandom), 1'($urandom_range(0, 5) == 0),
          1'($urandom),
          $urandom_range(0, 2) == 0 ? 4'hC :
          ($urandom_range(0, 1) == 0 ? 4'hD : 4'($urandom)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
